// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, error codes
// and the FSM state type.
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/half lane of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module load_align_extend
   import mips_mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        zero_ext,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (addr)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         SZ_BYTE: data = zero_ext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         SZ_HALF: data = zero_ext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: takes one EX/MEM op at a time, drives a handshaked
// multi-cycle data memory and returns an aligned, extended result to MEM/WB.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [31:0]       in_address,
   input  logic [31:0]       in_write_data,
   input  logic [4:0]        in_write_register,
   input  logic              in_mem_to_register,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_byte_en,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              out_valid,
   output logic [31:0]       out_read_data,
   output logic [31:0]       out_alu_result,
   output logic [4:0]        out_write_register,
   output logic              out_mem_to_register,
   output logic [1:0]        out_error
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // Handshakes: an op transfers on a rising edge with in_valid && in_ready;
   // a memory request transfers on a rising edge with mem_req && mem_ready,
   // and mem_req plus its address/data/enables stay constant until then.
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             start_req, req_drop, load_res;
   logic [31:0]      res_rdata, res_alu;
   logic [4:0]       res_wreg;
   logic             res_m2r;
   logic [1:0]       res_err;

   logic [31:0]      op_addr;
   logic [1:0]       op_size;
   logic             op_unsigned, op_read, op_m2r;
   logic [4:0]       op_wreg;

   logic             is_mem, illegal, misalign;
   logic [3:0]       req_be;
   logic [31:0]      req_wdata, aligned;

   load_align_extend u_align (
      .rdata    (mem_rdata),
      .addr     (op_addr[1:0]),
      .size     (op_size),
      .zero_ext (op_unsigned),
      .data     (aligned)
   );

   assign is_mem    = in_mem_read | in_mem_write;
   assign illegal   = (in_mem_read & in_mem_write) | (is_mem & (in_size == 2'd3));
   assign misalign  = ((in_size == SZ_HALF) & in_address[0]) |
                      ((in_size == SZ_WORD) & (in_address[1:0] != 2'd0));
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_RESULT);

   // Store-lane placement; loads always fetch the full word.
   always_comb begin
      req_be    = 4'b1111;
      req_wdata = 32'd0;
      if (in_mem_write) begin
         case (in_size)
            SZ_BYTE: begin
               req_be    = 4'b0001 << in_address[1:0];
               req_wdata = {4{in_write_data[7:0]}};
            end
            SZ_HALF: begin
               req_be    = in_address[1] ? 4'b1100 : 4'b0011;
               req_wdata = {2{in_write_data[15:0]}};
            end
            default: req_wdata = in_write_data;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_req = 1'b0;
      req_drop  = 1'b0;
      load_res  = 1'b0;
      res_rdata = 32'd0;
      res_alu   = 32'd0;
      res_wreg  = 5'd0;
      res_m2r   = 1'b0;
      res_err   = ERR_NONE;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               res_alu = in_address;
               if (!is_mem) begin
                  state_d  = ST_RESULT;
                  load_res = 1'b1;
                  res_wreg = in_write_register;
                  res_m2r  = in_mem_to_register;
               end else if (illegal || misalign) begin
                  state_d  = ST_RESULT;
                  load_res = 1'b1;
                  res_err  = illegal ? ERR_ILLEGAL : ERR_MISALIGN;
               end else begin
                  state_d   = ST_ACCESS;
                  start_req = 1'b1;
                  cnt_d     = '0;
               end
            end
         end
         ST_ACCESS: begin
            res_alu = op_addr;
            if (mem_ready) begin
               state_d   = ST_RESULT;
               req_drop  = 1'b1;
               load_res  = 1'b1;
               res_rdata = op_read ? aligned : 32'd0;
               res_wreg  = op_wreg;
               res_m2r   = op_m2r;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_RESULT;
               req_drop = 1'b1;
               load_res = 1'b1;
               res_err  = ERR_TIMEOUT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESULT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q               <= '0;
         mem_req             <= 1'b0;
         mem_we              <= 1'b0;
         mem_addr            <= '0;
         mem_byte_en         <= 4'd0;
         mem_wdata           <= 32'd0;
         op_addr             <= 32'd0;
         op_size             <= 2'd0;
         op_unsigned         <= 1'b0;
         op_read             <= 1'b0;
         op_wreg             <= 5'd0;
         op_m2r              <= 1'b0;
         out_read_data       <= 32'd0;
         out_alu_result      <= 32'd0;
         out_write_register  <= 5'd0;
         out_mem_to_register <= 1'b0;
         out_error           <= ERR_NONE;
      end else begin
         cnt_q <= cnt_d;
         if (start_req) begin
            mem_req     <= 1'b1;
            mem_we      <= in_mem_write;
            mem_addr    <= in_address[ADDR_W+1:2];
            mem_byte_en <= req_be;
            mem_wdata   <= req_wdata;
            op_addr     <= in_address;
            op_size     <= in_size;
            op_unsigned <= in_unsigned;
            op_read     <= in_mem_read;
            op_wreg     <= in_write_register;
            op_m2r      <= in_mem_to_register;
         end else if (req_drop) begin
            mem_req <= 1'b0;
         end
         // Result fields are only rewritten on entry to RESULT, so they hold between pulses.
         if (load_res) begin
            out_read_data       <= res_rdata;
            out_alu_result      <= res_alu;
            out_write_register  <= res_wreg;
            out_mem_to_register <= res_m2r;
            out_error           <= res_err;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a vector table applied through a small
// memory responder, plus hand-written reset and back-to-back sequences.
module tb_mem_access_unit;
   import mips_mem_pkg::*;

   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_mem_read = 1'b0;
   logic              in_mem_write = 1'b0;
   logic [1:0]        in_size = 2'd0;
   logic              in_unsigned = 1'b0;
   logic [31:0]       in_address = 32'd0;
   logic [31:0]       in_write_data = 32'd0;
   logic [4:0]        in_write_register = 5'd0;
   logic              in_mem_to_register = 1'b0;
   logic              mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_byte_en;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = 32'd0;
   logic              mem_ready = 1'b0;
   logic              out_valid;
   logic [31:0]       out_read_data, out_alu_result;
   logic [4:0]        out_write_register;
   logic              out_mem_to_register;
   logic [1:0]        out_error;

   int total = 0;
   int bad = 0;

   mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
      .in_size(in_size), .in_unsigned(in_unsigned),
      .in_address(in_address), .in_write_data(in_write_data),
      .in_write_register(in_write_register), .in_mem_to_register(in_mem_to_register),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .out_valid(out_valid), .out_read_data(out_read_data),
      .out_alu_result(out_alu_result), .out_write_register(out_write_register),
      .out_mem_to_register(out_mem_to_register), .out_error(out_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  wreg;
      logic        m2r;
      int          waits;
      logic [31:0] rdata;
      int          req_cyc;
      logic [15:0] maddr;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] exp_rd;
      logic [1:0]  err;
      logic [4:0]  exp_wreg;
      logic        exp_m2r;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive_op(input vec_t v);
      in_mem_read        = v.rd;
      in_mem_write       = v.wr;
      in_size            = v.sz;
      in_unsigned        = v.uns;
      in_address         = v.addr;
      in_write_data      = v.wdata;
      in_write_register  = v.wreg;
      in_mem_to_register = v.m2r;
      in_valid           = 1'b1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int c, waits_left, req_seen;
      bit got;
      string p;
      p = $sformatf("v%0d", idx);
      for (int w = 0; w < 10 && !in_ready; w++) @(negedge clk);
      chk({p, "_in_ready"}, in_ready, 1);
      drive_op(v);
      @(posedge clk);
      #1 in_valid = 1'b0;
      c = 1; got = 0; req_seen = 0; waits_left = v.waits;
      while (c <= 40 && !got) begin
         if (mem_req) begin
            req_seen++;
            chk({p, "_we"}, mem_we, v.wr);
            chk({p, "_addr"}, mem_addr, v.maddr);
            chk({p, "_be"}, mem_byte_en, v.be);
            if (v.wr) chk({p, "_wdata"}, mem_wdata, v.mwdata);
            if (waits_left == 0) begin
               mem_ready = 1'b1;
               mem_rdata = v.rdata;
            end else begin
               waits_left--;
            end
         end
         if (out_valid) begin
            got = 1;
            chk({p, "_lat"}, c, v.lat);
            chk({p, "_rdata"}, out_read_data, v.exp_rd);
            chk({p, "_alu"}, out_alu_result, v.addr);
            chk({p, "_wreg"}, out_write_register, v.exp_wreg);
            chk({p, "_m2r"}, out_mem_to_register, v.exp_m2r);
            chk({p, "_err"}, out_error, v.err);
         end else begin
            @(posedge clk);
            #1 mem_ready = 1'b0;
            c++;
         end
      end
      chk({p, "_done"}, got, 1);
      chk({p, "_req_cycles"}, req_seen, v.req_cyc);
   endtask

   initial begin
      //           rd wr sz uns addr          wdata         wreg m2r wt rdata         rq maddr  be     mwdata        exp_rd        err wreg m2r lat
      vecs[0]  = '{1, 0, 2, 0, 32'h4,        32'h0,        8,   1,  2, 32'd3123,     3, 16'h1, 4'hF,  32'h0,        32'd3123,     0,  8,   1,  4};
      vecs[1]  = '{1, 0, 0, 0, 32'h3,        32'h0,        9,   1,  0, 32'h80FF1234, 1, 16'h0, 4'hF,  32'h0,        32'hFFFFFF80, 0,  9,   1,  2};
      vecs[2]  = '{1, 0, 0, 1, 32'h3,        32'h0,        9,   1,  0, 32'h80FF1234, 1, 16'h0, 4'hF,  32'h0,        32'h00000080, 0,  9,   1,  2};
      vecs[3]  = '{1, 0, 0, 1, 32'h2,        32'h0,        9,   1,  0, 32'h80FF1234, 1, 16'h0, 4'hF,  32'h0,        32'h000000FF, 0,  9,   1,  2};
      vecs[4]  = '{1, 0, 0, 0, 32'h0,        32'h0,        2,   1,  1, 32'h80FF1234, 2, 16'h0, 4'hF,  32'h0,        32'h00000034, 0,  2,   1,  3};
      vecs[5]  = '{1, 0, 1, 0, 32'h2,        32'h0,        5,   1,  1, 32'h80FF1234, 2, 16'h0, 4'hF,  32'h0,        32'hFFFF80FF, 0,  5,   1,  3};
      vecs[6]  = '{1, 0, 1, 0, 32'h102,      32'h0,        6,   1,  0, 32'h7FFF8001, 1, 16'h40, 4'hF, 32'h0,        32'h00007FFF, 0,  6,   1,  2};
      vecs[7]  = '{0, 1, 1, 0, 32'h6,        32'h0000ABCD, 3,   0,  3, 32'h0,        4, 16'h1, 4'hC,  32'hABCDABCD, 32'h0,        0,  3,   0,  5};
      vecs[8]  = '{0, 1, 0, 0, 32'h9,        32'h123456A5, 4,   0,  1, 32'h0,        2, 16'h2, 4'h2,  32'hA5A5A5A5, 32'h0,        0,  4,   0,  3};
      vecs[9]  = '{0, 1, 2, 0, 32'h00040010, 32'hDEADBEEF, 1,   0,  0, 32'h0,        1, 16'h4, 4'hF,  32'hDEADBEEF, 32'h0,        0,  1,   0,  2};
      vecs[10] = '{1, 0, 2, 0, 32'h5,        32'h0,        7,   1,  0, 32'h0,        0, 16'h0, 4'h0,  32'h0,        32'h0,        1,  0,   0,  1};
      vecs[11] = '{0, 1, 1, 0, 32'h3,        32'h1111,     7,   0,  0, 32'h0,        0, 16'h0, 4'h0,  32'h0,        32'h0,        1,  0,   0,  1};
      vecs[12] = '{1, 0, 3, 0, 32'h0,        32'h0,        7,   1,  0, 32'h0,        0, 16'h0, 4'h0,  32'h0,        32'h0,        2,  0,   0,  1};
      vecs[13] = '{1, 1, 2, 0, 32'h0,        32'h0,        7,   1,  0, 32'h0,        0, 16'h0, 4'h0,  32'h0,        32'h0,        2,  0,   0,  1};
      vecs[14] = '{0, 0, 0, 0, 32'd69,       32'h0,        13,  0,  0, 32'h0,        0, 16'h0, 4'h0,  32'h0,        32'h0,        0,  13,  0,  1};
      vecs[15] = '{1, 0, 2, 0, 32'h8,        32'h0,        10,  1, 99, 32'h0,       15, 16'h2, 4'hF,  32'h0,        32'h0,        3,  0,   0,  16};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_out_error", out_error, 0);
      chk("rst_out_rdata", out_read_data, 0);
      chk("rst_out_wreg", out_write_register, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Reset while a load is waiting on the memory.
      for (int w = 0; w < 10 && !in_ready; w++) @(negedge clk);
      drive_op(vecs[0]);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("mid_rst_req_before", mem_req, 1);
      @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      chk("mid_rst_req", mem_req, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      @(negedge clk) rst_n = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid || mem_req) seen++;
         end
         chk("mid_rst_no_result", seen, 0);
      end

      // Back-to-back non-memory ops: second is held during RESULT, taken in IDLE.
      drive_op(vecs[14]);
      @(posedge clk);
      #1;
      chk("b2b_a_valid", out_valid, 1);
      chk("b2b_a_alu", out_alu_result, 69);
      chk("b2b_busy", in_ready, 0);
      in_address = 32'd100;
      in_write_register = 5'd14;
      @(posedge clk);
      #1;
      chk("b2b_pulse_end", out_valid, 0);
      chk("b2b_idle_ready", in_ready, 1);
      chk("b2b_hold_alu", out_alu_result, 69);
      chk("b2b_hold_wreg", out_write_register, 13);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("b2b_b_valid", out_valid, 1);
      chk("b2b_b_alu", out_alu_result, 100);
      chk("b2b_b_wreg", out_write_register, 14);
      chk("b2b_b_no_req", mem_req, 0);
      @(posedge clk);
      #1 chk("b2b_b_end", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
